// File: rtl/por_pkg.sv
// Shared constants and FSM state type for the power-on reset sequencer.
package por_pkg;

    localparam int NUM_DOM             = 3;
    localparam int STAGE_DLY_DEF       = 64;
    localparam int STAGE_DLY_SHORT_DEF = 4;
    localparam int ACK_TIMEOUT_DEF     = 1024;
    localparam int BO_MAX              = 15;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DELAY    = 3'd1,
        WAIT_ACK = 3'd2,
        DONE     = 3'd3,
        FAULT    = 3'd4
    } seq_state_e;

endpackage

// File: rtl/por_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear.
module por_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/por_rst_seq.sv
// Power-on reset sequencer: releases three domain resets in order, waiting for each acknowledge.
//
// state    | meaning
// IDLE     | all domains held in reset, waiting for avdd good
// DELAY    | counting the stage delay before releasing domain k
// WAIT_ACK | domain k released, waiting for its ready (bounded by timeout)
// DONE     | all domains released and acknowledged
// FAULT    | an acknowledge timed out; all domains held in reset
module por_rst_seq
    import por_pkg::*;
#(
    parameter int STAGE_DLY       = STAGE_DLY_DEF,
    parameter int STAGE_DLY_SHORT = STAGE_DLY_SHORT_DEF,
    parameter int ACK_TIMEOUT     = ACK_TIMEOUT_DEF
) (
    input  logic         osc_ck,
    input  logic         porb,
    input  logic         pwup_filt,
    input  logic         force_short_oneshot,
    input  logic [2:0]   dom_ready,
    output logic [2:0]   rst_n_out,
    output logic         seq_done,
    output logic         seq_fault,
    output logic [3:0]   brownout_cnt
);

    localparam int CNT_MAX_A = (STAGE_DLY > STAGE_DLY_SHORT) ? STAGE_DLY : STAGE_DLY_SHORT;
    localparam int CNT_MAX   = (ACK_TIMEOUT > CNT_MAX_A) ? ACK_TIMEOUT : CNT_MAX_A;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DLY_LD   = CNT_W'(STAGE_DLY - 1);
    localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(STAGE_DLY_SHORT - 1);
    localparam logic [CNT_W-1:0] TMO_LD   = CNT_W'(ACK_TIMEOUT - 1);

    logic               rst_sync_n;
    logic               pwup_s;
    logic [NUM_DOM-1:0] ready_s;

    seq_state_e         state, state_nxt;
    logic [1:0]         k, k_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [NUM_DOM-1:0] rst_nxt;
    logic               done_nxt, fault_nxt;
    logic [3:0]         bo_nxt;
    logic [CNT_W-1:0]   dly_load;

    por_sync2 u_rst_sync (.clk(osc_ck), .rst_n(porb), .d(1'b1),      .q(rst_sync_n));
    por_sync2 u_pwup_sync (.clk(osc_ck), .rst_n(porb), .d(pwup_filt), .q(pwup_s));

    for (genvar i = 0; i < NUM_DOM; i++) begin : g_ready_sync
        por_sync2 u_ready_sync (.clk(osc_ck), .rst_n(porb), .d(dom_ready[i]), .q(ready_s[i]));
    end

    // The delay select is only consumed on the transitions that enter DELAY.
    assign dly_load = force_short_oneshot ? SHORT_LD : DLY_LD;

    always_ff @(posedge osc_ck or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state        <= IDLE;
            k            <= 2'd0;
            cnt          <= '0;
            rst_n_out    <= '0;
            seq_done     <= 1'b0;
            seq_fault    <= 1'b0;
            brownout_cnt <= 4'd0;
        end else begin
            state        <= state_nxt;
            k            <= k_nxt;
            cnt          <= cnt_nxt;
            rst_n_out    <= rst_nxt;
            seq_done     <= done_nxt;
            seq_fault    <= fault_nxt;
            brownout_cnt <= bo_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        cnt_nxt   = cnt;
        rst_nxt   = rst_n_out;
        done_nxt  = seq_done;
        fault_nxt = seq_fault;
        bo_nxt    = brownout_cnt;

        if (state != IDLE && !pwup_s) begin
            state_nxt = IDLE;
            k_nxt     = 2'd0;
            rst_nxt   = '0;
            done_nxt  = 1'b0;
            if (brownout_cnt != 4'(BO_MAX)) begin
                bo_nxt = brownout_cnt + 4'd1;
            end
        end else begin
            case (state)
                IDLE: begin
                    rst_nxt = '0;
                    k_nxt   = 2'd0;
                    if (pwup_s) begin
                        state_nxt = DELAY;
                        cnt_nxt   = dly_load;
                    end
                end
                DELAY: begin
                    if (cnt == '0) begin
                        rst_nxt[k] = 1'b1;
                        state_nxt  = WAIT_ACK;
                        cnt_nxt    = TMO_LD;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                WAIT_ACK: begin
                    // Acknowledge is tested first so it wins over a coincident timeout.
                    if (ready_s[k]) begin
                        if (k == 2'd2) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            k_nxt     = k + 2'd1;
                            state_nxt = DELAY;
                            cnt_nxt   = dly_load;
                        end
                    end else if (cnt == '0) begin
                        state_nxt = FAULT;
                        rst_nxt   = '0;
                        fault_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                DONE: begin
                    done_nxt = 1'b1;
                end
                FAULT: begin
                    rst_nxt   = '0;
                    fault_nxt = 1'b1;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_por_rst_seq.sv
// Self-checking bench for por_rst_seq: expected release/done/fault edges computed from stimulus timing.
module tb_por_rst_seq;

    logic       osc_ck = 1'b0;
    logic       porb;
    logic       pwup_filt;
    logic       force_short_oneshot;
    logic [2:0] dom_ready;
    logic [2:0] rst_n_out;
    logic       seq_done;
    logic       seq_fault;
    logic [3:0] brownout_cnt;

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;
    int exp_bo  = 0;

    // Input edge to action: 2 edges through the synchronizer plus 1 for the FSM.
    localparam int SYNC_LAT = 3;
    localparam int T_ACK    = 1024;

    por_rst_seq dut (
        .osc_ck              (osc_ck),
        .porb                (porb),
        .pwup_filt           (pwup_filt),
        .force_short_oneshot (force_short_oneshot),
        .dom_ready           (dom_ready),
        .rst_n_out           (rst_n_out),
        .seq_done            (seq_done),
        .seq_fault           (seq_fault),
        .brownout_cnt        (brownout_cnt)
    );

    always #5 osc_ck = ~osc_ck;
    always @(posedge osc_ck) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic sig_of(input int sel);
        case (sel)
            0, 1, 2: return rst_n_out[sel[1:0]];
            3:       return seq_done;
            default: return seq_fault;
        endcase
    endfunction

    // Returns the posedge index after which the selected signal was first seen high, or -1.
    task automatic wait_hi(input int sel, input int limit, output int edge_no);
        edge_no = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge osc_ck);
            if (sig_of(sel)) begin
                edge_no = cyc;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge osc_ck);
        porb = 1'b0; pwup_filt = 1'b0; dom_ready = 3'b000; force_short_oneshot = 1'b0;
        repeat (3) @(negedge osc_ck);
        chk("rst_rst_n_out", 32'(rst_n_out), 0);
        chk("rst_seq_done", 32'(seq_done), 0);
        chk("rst_seq_fault", 32'(seq_fault), 0);
        chk("rst_brownout", 32'(brownout_cnt), 0);
        porb = 1'b1;
        exp_bo = 0;
        repeat (4) @(negedge osc_ck);
    endtask

    // Walks the stages; stops right after release of stop_k (3 = full sequence).
    task automatic run_seq(input int start, input int dly, input int stop_k, input int a_fix,
                           output int last_rel);
        int exp_rel, got, a, t_act;
        exp_rel  = start + SYNC_LAT + dly;
        t_act    = 0;
        last_rel = -1;
        for (int k = 0; k < 3; k++) begin
            wait_hi(k, 3000, got);
            chk($sformatf("rel_edge_%0d", k), got, exp_rel);
            chk($sformatf("rel_pattern_%0d", k), 32'(rst_n_out), (1 << (k + 1)) - 1);
            last_rel = got;
            if (k == stop_k) return;
            if (dom_ready[k]) begin
                t_act = got + 1;
            end else begin
                a = (a_fix >= 0) ? a_fix : int'($urandom_range(0, 12));
                repeat (a) @(negedge osc_ck);
                dom_ready[k] = 1'b1;
                t_act = cyc + SYNC_LAT;
            end
            exp_rel = t_act + dly;
        end
        wait_hi(3, 200, got);
        chk("done_edge", got, t_act);
        chk("done_rst_n_out", 32'(rst_n_out), 7);
        chk("done_fault", 32'(seq_fault), 0);
        chk("done_brownout", 32'(brownout_cnt), exp_bo);
    endtask

    initial begin
        int s, r, b, got, off;
        porb = 1'b0; pwup_filt = 1'b0; dom_ready = 3'b000; force_short_oneshot = 1'b0;

        // Nominal sequence, acknowledges 5 cycles after each release.
        do_reset();
        pwup_filt = 1'b1; s = cyc;
        run_seq(s, 64, 3, 5, r);

        // Random acknowledge latencies.
        for (int it = 0; it < 2; it++) begin
            do_reset();
            pwup_filt = 1'b1; s = cyc;
            run_seq(s, 64, 3, -1, r);
        end

        // Early acks on unreleased domains must not advance stage 0.
        do_reset();
        dom_ready = 3'b110;
        pwup_filt = 1'b1; s = cyc;
        run_seq(s, 64, 3, -1, r);

        // Short one-shot delay.
        do_reset();
        force_short_oneshot = 1'b1;
        pwup_filt = 1'b1; s = cyc;
        run_seq(s, 4, 3, -1, r);
        force_short_oneshot = 1'b0;

        // Stage 0 ack coincides with timeout (ack wins); stage 1 never acks -> fault.
        do_reset();
        pwup_filt = 1'b1; s = cyc;
        run_seq(s, 64, 1, T_ACK - SYNC_LAT, r);
        wait_hi(4, 1200, got);
        chk("fault_edge", got, r + T_ACK);
        chk("fault_rst_n_out", 32'(rst_n_out), 0);
        chk("fault_seq_done", 32'(seq_done), 0);
        dom_ready = 3'b000;
        pwup_filt = 1'b0;
        repeat (4) @(negedge osc_ck);
        exp_bo = 1;
        chk("fault_bo", 32'(brownout_cnt), exp_bo);
        chk("fault_sticky_low", 32'(seq_fault), 1);
        pwup_filt = 1'b1;
        repeat (10) @(negedge osc_ck);
        chk("fault_sticky_high", 32'(seq_fault), 1);

        // Brownout during WAIT_ACK at k=1, then full re-sequence.
        do_reset();
        pwup_filt = 1'b1; s = cyc;
        run_seq(s, 64, 1, -1, r);
        off = int'($urandom_range(0, 20));
        repeat (off) @(negedge osc_ck);
        b = cyc;
        pwup_filt = 1'b0;
        repeat (2) @(negedge osc_ck);
        chk("bo_before", 32'(rst_n_out), 3);
        @(negedge osc_ck);
        exp_bo = exp_bo + 1;
        chk("bo_rst_n_out", 32'(rst_n_out), 0);
        chk("bo_cnt", 32'(brownout_cnt), exp_bo);
        chk("bo_edge", cyc, b + SYNC_LAT);
        dom_ready = 3'b000;
        pwup_filt = 1'b1; s = cyc;
        run_seq(s, 64, 3, -1, r);

        // Brownout counter saturation.
        do_reset();
        pwup_filt = 1'b1;
        repeat (10) @(negedge osc_ck);
        for (int i = 1; i <= 17; i++) begin
            pwup_filt = 1'b0;
            repeat (3) @(negedge osc_ck);
            exp_bo = (exp_bo < 15) ? exp_bo + 1 : 15;
            chk($sformatf("sat_cnt_%0d", i), 32'(brownout_cnt), exp_bo);
            pwup_filt = 1'b1;
            repeat (6) @(negedge osc_ck);
        end

        // porb asserted in DELAY at k=2 clears everything before the next edge.
        do_reset();
        pwup_filt = 1'b1; s = cyc;
        run_seq(s, 64, 1, -1, r);
        dom_ready[1] = 1'b1;
        repeat (12) @(negedge osc_ck);
        chk("porb_pre_rst_n_out", 32'(rst_n_out), 3);
        #2;
        porb = 1'b0;
        #1;
        chk("porb_rst_n_out", 32'(rst_n_out), 0);
        chk("porb_seq_done", 32'(seq_done), 0);
        chk("porb_seq_fault", 32'(seq_fault), 0);
        chk("porb_brownout", 32'(brownout_cnt), 0);
        repeat (3) @(negedge osc_ck);
        chk("porb_hold", 32'(rst_n_out), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
